// File: rtl/comparator_serial_ctrl_if.sv
// Compare-job bus between a requester (master) and the serial comparator (slave).
interface comparator_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (output start, a, b, input busy, done, lt, gt, eq);
  modport slave  (input start, a, b, output busy, done, lt, gt, eq);
endinterface

// File: rtl/comparator_serial_ctrl.sv
// Serial magnitude comparator: walks 2-bit slices MSB first, one per clock.
// Optional macro COMP_EARLY_EXIT_EN ends the scan on the first unequal slice.
module comparator_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  comparator_serial_ctrl_if.slave cmp
);
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    idx_q;
  logic             decided_q, dir_q;
  logic             lt_q, gt_q, eq_q;

  logic [1:0] a_sl [N];
  logic [1:0] b_sl [N];
  logic [1:0] cur_a, cur_b;
  logic       slice_ne, slice_gt;
  logic       decided_d, dir_d;
  logic       last_slice, early_hit, accept, finish;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_sl[gi] = a_q[2*gi +: 2];
      assign b_sl[gi] = b_q[2*gi +: 2];
    end
  endgenerate

  assign cur_a      = a_sl[idx_q];
  assign cur_b      = b_sl[idx_q];
  assign slice_ne   = (cur_a != cur_b);
  assign slice_gt   = (cur_a > cur_b);
  // The first unequal slice (MSB first) fixes the direction for good.
  assign decided_d  = decided_q | slice_ne;
  assign dir_d      = decided_q ? dir_q : slice_gt;
  assign last_slice = (idx_q == '0);

`ifdef COMP_EARLY_EXIT_EN
  assign early_hit = ~decided_q & slice_ne;
`else
  assign early_hit = 1'b0;
`endif

  assign accept = cmp.start && (state_q != RUN);
  assign finish = (state_q == RUN) && (last_slice || early_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmp.start) state_d = RUN;
      RUN:     if (last_slice || early_hit) state_d = DONE;
      DONE:    state_d = cmp.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmp.busy = (state_q == RUN);
    cmp.done = (state_q == DONE);
    cmp.lt   = lt_q;
    cmp.gt   = gt_q;
    cmp.eq   = eq_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      dir_q     <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else if (accept) begin
      a_q       <= cmp.a;
      b_q       <= cmp.b;
      idx_q     <= CW'(N - 1);
      decided_q <= 1'b0;
      dir_q     <= 1'b0;
    end else if (state_q == RUN) begin
      decided_q <= decided_d;
      dir_q     <= dir_d;
      if (!last_slice) idx_q <= idx_q - CW'(1);
      // Flags only move on the edge that enters DONE.
      if (finish) begin
        eq_q <= ~decided_d;
        gt_q <= decided_d & dir_d;
        lt_q <= decided_d & ~dir_d;
      end
    end
  end
endmodule
